// File: rtl/multi_lane_fp_multiplier.sv
// Batch wrapper around NUM_LANES single-precision multiplier cores: staggered launch,
// per-lane result capture, then an in-order serial result stream and a done pulse.

// Single-precision multiplier core: three-cycle latency, round-to-nearest-even,
// subnormal inputs and results flushed to signed zero.
module verilog_multiplier (
    input  logic        clk,
    input  logic        rst,
    input  logic        ready,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    output logic [31:0] res,
    output logic        done
);
    localparam logic [1:0] K_NORM = 2'd0;
    localparam logic [1:0] K_ZERO = 2'd1;
    localparam logic [1:0] K_INF  = 2'd2;
    localparam logic [1:0] K_NAN  = 2'd3;

    logic [31:0]        a_q, b_q;
    logic               v1, v2;
    logic               s2_sign;
    logic signed [9:0]  s2_exp;
    logic [47:0]        s2_prod;
    logic [1:0]         s2_kind;

    logic               c_sign;
    logic signed [9:0]  c_exp;
    logic [47:0]        c_prod;
    logic [1:0]         c_kind;
    logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

    // Operand classification and significand product
    always_comb begin
        a_zero = (a_q[30:23] == 8'd0);
        b_zero = (b_q[30:23] == 8'd0);
        a_inf  = (a_q[30:23] == 8'hFF) && (a_q[22:0] == 23'd0);
        b_inf  = (b_q[30:23] == 8'hFF) && (b_q[22:0] == 23'd0);
        a_nan  = (a_q[30:23] == 8'hFF) && (a_q[22:0] != 23'd0);
        b_nan  = (b_q[30:23] == 8'hFF) && (b_q[22:0] != 23'd0);
        c_sign = a_q[31] ^ b_q[31];
        c_exp  = $signed({2'b00, a_q[30:23]}) + $signed({2'b00, b_q[30:23]}) - 10'sd127;
        c_prod = 48'({1'b1, a_q[22:0]}) * 48'({1'b1, b_q[22:0]});
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) c_kind = K_NAN;
        else if (a_inf || b_inf)                                      c_kind = K_INF;
        else if (a_zero || b_zero)                                    c_kind = K_ZERO;
        else                                                          c_kind = K_NORM;
    end

    logic [22:0]        frac;
    logic               guard, sticky, rnd;
    logic [23:0]        frac_r;
    logic signed [9:0]  exp_n;
    logic [31:0]        packed_w;

    // Normalise, round to nearest even, pack
    always_comb begin
        if (s2_prod[47]) begin
            frac   = s2_prod[46:24];
            guard  = s2_prod[23];
            sticky = |s2_prod[22:0];
            exp_n  = s2_exp + 10'sd1;
        end else begin
            frac   = s2_prod[45:23];
            guard  = s2_prod[22];
            sticky = |s2_prod[21:0];
            exp_n  = s2_exp;
        end
        rnd    = guard & (sticky | frac[0]);
        frac_r = {1'b0, frac} + 24'(rnd);
        if (frac_r[23]) exp_n = exp_n + 10'sd1;
        case (s2_kind)
            K_NAN:   packed_w = 32'h7FC0_0000;
            K_INF:   packed_w = {s2_sign, 8'hFF, 23'd0};
            K_ZERO:  packed_w = {s2_sign, 31'd0};
            default: begin
                if (exp_n >= 10'sd255)    packed_w = {s2_sign, 8'hFF, 23'd0};
                else if (exp_n <= 10'sd0) packed_w = {s2_sign, 31'd0};
                else                      packed_w = {s2_sign, exp_n[7:0], frac_r[22:0]};
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            v1      <= 1'b0;
            v2      <= 1'b0;
            s2_sign <= 1'b0;
            s2_exp  <= '0;
            s2_prod <= '0;
            s2_kind <= K_ZERO;
            res     <= '0;
            done    <= 1'b0;
        end else begin
            v1   <= ready;
            v2   <= v1;
            done <= v2;
            if (ready) begin
                a_q <= op1;
                b_q <= op2;
            end
            if (v1) begin
                s2_sign <= c_sign;
                s2_exp  <= c_exp;
                s2_prod <= c_prod;
                s2_kind <= c_kind;
            end
            if (v2) res <= packed_w;
        end
    end
endmodule

module multi_lane_fp_multiplier #(
    parameter int unsigned NUM_LANES = 4,
    parameter int unsigned STAGGER   = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [NUM_LANES-1:0]        lane_mask,
    input  logic [32*NUM_LANES-1:0]     op1,
    input  logic [32*NUM_LANES-1:0]     op2,
    output logic                        busy,
    output logic [31:0]                 res,
    output logic [((NUM_LANES > 1) ? $clog2(NUM_LANES) : 1)-1:0] res_lane,
    output logic                        res_valid,
    output logic                        res_last,
    output logic                        done
);
    localparam int unsigned LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int unsigned CNT_W  = 5;

    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, DRAIN, FINISH} state_t;

    state_t                     state, state_next;
    logic [32*NUM_LANES-1:0]    a_q, b_q;
    logic [NUM_LANES-1:0]       mask_q, captured, launched, pend;
    logic [31:0]                tick;
    logic [31:0]                cap_res  [NUM_LANES];

    logic [NUM_LANES-1:0]       lane_ready, lane_done, honour, cap_next;
    logic [31:0]                lane_res [NUM_LANES];
    logic [31:0]                val      [NUM_LANES];
    logic [CNT_W-1:0]           rank     [NUM_LANES];
    logic [CNT_W-1:0]           nact;
    logic [31:0]                launch_end;
    logic                       launch_last, all_cap, go_emit, in_capture;
    logic [NUM_LANES-1:0]       src, rem;
    logic [LANE_W-1:0]          sel_idx;

    logic                       busy_d, valid_d, last_d, done_d;
    logic [31:0]                res_d;
    logic [LANE_W-1:0]          lane_d;

    function automatic logic [LANE_W-1:0] lowest(input logic [NUM_LANES-1:0] v);
        lowest = '0;
        for (int k = NUM_LANES - 1; k >= 0; k--) begin
            if (v[k]) lowest = LANE_W'(k);
        end
    endfunction

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        verilog_multiplier u_mul (
            .clk   (clk),
            .rst   (rst),
            .ready (lane_ready[g]),
            .op1   (a_q[32*g +: 32]),
            .op2   (b_q[32*g +: 32]),
            .res   (lane_res[g]),
            .done  (lane_done[g])
        );
    end

    // Launch slot of each active lane and number of active lanes
    always_comb begin
        nact = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            rank[k] = nact;
            nact    = nact + CNT_W'(mask_q[k]);
        end
    end

    // Lane handshakes, capture qualification and drain selection
    always_comb begin
        in_capture  = (state == LAUNCH) || (state == WAIT);
        launch_end  = (32'(nact) - 32'd1) * STAGGER;
        launch_last = (tick == launch_end);
        for (int k = 0; k < NUM_LANES; k++) begin
            lane_ready[k] = (state == LAUNCH) && mask_q[k] && (tick == 32'(rank[k]) * STAGGER);
            honour[k]     = in_capture && launched[k] && !captured[k] && lane_done[k];
            val[k]        = honour[k] ? lane_res[k] : cap_res[k];
        end
        cap_next = captured | honour;
        all_cap  = (cap_next == mask_q);
        go_emit  = ((state == LAUNCH) && launch_last && all_cap) ||
                   ((state == WAIT) && all_cap) ||
                   ((state == DRAIN) && (pend != '0));
        src      = (state == DRAIN) ? pend : mask_q;
        sel_idx  = lowest(src);
        rem      = src & ~(NUM_LANES'(1) << sel_idx);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = (lane_mask != '0) ? LAUNCH : FINISH;
            LAUNCH:  if (launch_last) state_next = all_cap ? DRAIN : WAIT;
            WAIT:    if (all_cap) state_next = DRAIN;
            DRAIN:   if (pend == '0) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        busy_d  = (state_next != IDLE);
        done_d  = (state_next == FINISH);
        valid_d = go_emit;
        last_d  = go_emit && (rem == '0);
        res_d   = res;
        lane_d  = res_lane;
        if (go_emit) begin
            res_d  = val[sel_idx];
            lane_d = sel_idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy      <= 1'b0;
            res       <= '0;
            res_lane  <= '0;
            res_valid <= 1'b0;
            res_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            busy      <= busy_d;
            res       <= res_d;
            res_lane  <= lane_d;
            res_valid <= valid_d;
            res_last  <= last_d;
            done      <= done_d;
        end
    end

    // Batch operands, lane bookkeeping and captured results
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            mask_q   <= '0;
            captured <= '0;
            launched <= '0;
            pend     <= '0;
            tick     <= '0;
            for (int k = 0; k < NUM_LANES; k++) cap_res[k] <= '0;
        end else begin
            if (state == IDLE) begin
                tick <= '0;
                if (start && (lane_mask != '0)) begin
                    a_q      <= op1;
                    b_q      <= op2;
                    mask_q   <= lane_mask;
                    captured <= '0;
                    launched <= '0;
                end
            end else begin
                launched <= launched | lane_ready;
            end
            if (state == LAUNCH) tick <= tick + 32'd1;
            if (in_capture) captured <= cap_next;
            if (go_emit) pend <= rem;
            for (int k = 0; k < NUM_LANES; k++) begin
                if (honour[k]) cap_res[k] <= lane_res[k];
            end
        end
    end
endmodule

// File: doc/multi_lane_fp_multiplier.md
# multi_lane_fp_multiplier

Parametrised batch wrapper around `NUM_LANES` instances of the single-precision IEEE-754 core `verilog_multiplier`. Each instance has the interface clk, rst, ready, op1[31:0], op2[31:0], res[31:0], done. The block accepts one batch of per-lane operand pairs plus an active-lane mask, and launches the active lanes with a configurable stagger. It captures each lane's result when that lane reports done, then streams the results out serially in ascending lane order with index, valid and last markers, followed by a completion pulse. It generalises the fixed two-lane multiplier.

## Interface
- `NUM_LANES`, default 4: number of multiplier instances; valid range 1..16.
- `STAGGER`, default 1: cycles between successive lane launches. 0 launches all active lanes in the same cycle.
- `LANE_W`, derived local parameter: max(1, clog2(`NUM_LANES`)).
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-high. Also drives rst of every lane instance.
- `start` in 1: batch request; sampled only in IDLE.
- `lane_mask` in NUM_LANES: bit k=1 means lane k is active for this batch.
- `op1` in 32*NUM_LANES: lane k operand at [32k+31:32k].
- `op2` in 32*NUM_LANES: lane k operand at [32k+31:32k].
- `busy` out 1: high in every state except IDLE.
- `res` out 32: streamed result.
- `res_lane` out LANE_W: lane index of the current `res`.
- `res_valid` out 1: `res`/`res_lane` valid this cycle.
- `res_last` out 1: qualifies the final result of the batch.
- `done` out 1: one-cycle pulse marking batch completion.

## Operation
- All outputs are registered. Reset values: `busy`=0, `res`=0, `res_lane`=0, `res_valid`=0, `res_last`=0, `done`=0. All lane ready signals, the captured bits and the FSM also reset (FSM returns to IDLE).
- States: IDLE, LAUNCH, WAIT, DRAIN, FINISH.
- IDLE:
  - `start`=1 with `lane_mask`≠0: latch `op1`, `op2` and the mask, clear the captured bits, go to LAUNCH.
  - `start`=1 with `lane_mask`=0: go to FINISH. No lane is launched and no result is produced.
- `start` outside IDLE is ignored. Operand inputs are don't-care after the latch.
- LAUNCH:
  - The i-th active lane (ascending index; inactive lanes consume no slot) gets its ready high for exactly one cycle, i*`STAGGER` cycles after the first LAUNCH cycle.
  - Each lane is fed its latched operands.
  - After the last active lane's ready cycle, go to WAIT.
- Capture (active in LAUNCH and WAIT):
  - A lane's done is honoured only from the cycle after its ready pulse, and only while its captured bit is 0.
  - On an honoured done, register that lane's res and set its captured bit.
  - Several lanes may capture in the same cycle.
  - A done from an inactive or not-yet-launched lane is ignored.
- WAIT: when the captured bits equal the latched mask, go to DRAIN. The same rule applies on the final LAUNCH cycle if every lane has already captured.
- DRAIN:
  - One result per cycle in ascending lane index, skipping inactive lanes.
  - Each result drives `res_valid`=1 with the matching `res_lane`.
  - `res_last`=1 on the final one, then go to FINISH.
- FINISH: `done`=1 for one cycle, then IDLE. `busy` returns to 0 in the IDLE cycle.
- Results are bit-exact copies of the lane outputs; no arithmetic is done in this block.
- Reset mid-batch: immediate return to reset values. Partial results are discarded; nothing is emitted.

## Timing
- Cycle 0 is the edge where IDLE samples `start`=1.
- Lane launch: the i-th active lane's ready is high in cycle 1+i*`STAGGER`.
- Capture: let lane latency L be the number of cycles from the ready-high cycle to the cycle its done is sampled high. With equal L and N active lanes, the last capture edge is cycle 1+(N-1)*`STAGGER`+L (all lanes in the same cycle when `STAGGER`=0).
- Result stream: `res_valid` is high for N consecutive cycles starting the cycle after the last capture.
- Completion: `done` pulses in the cycle after `res_last`.
- Total cycles from `start` to `done` = 1+(N-1)*`STAGGER`+L+N+1.
- Back-to-back: a new `start` is accepted in the IDLE cycle following `done`.
- Empty mask: `done` is high in cycle 1; `res_valid` never asserts.

## Test plan
- NUM_LANES=4, mask=4'b1111, STAGGER=1, lane k operands (1.0,2.0), (3.0,3.0), (2.0,4.0), (-2.0,0.5) -> `res` stream 0x40000000, 0x41100000, 0x41000000, 0xBF800000 with `res_lane` 0..3, `res_last` on lane 3, `done` one cycle later.
- Same operands, mask=4'b1010 -> exactly two results, 0x41100000 (lane 1) then 0xBF800000 (lane 3) with `res_last`; lanes 0 and 2 never see ready.
- STAGGER=0 vs STAGGER=5 on identical operands -> identical result streams; start-to-`done` cycle count differs by exactly 15 with 4 active lanes.
- mask=0 with `start`=1 -> `done` in cycle 1, `busy` high for one cycle, `res_valid` stays 0.
- Assert `rst` while in WAIT, then a new batch with mask=4'b0001, operands (3.0,3.0) -> no stale outputs; single result 0x41100000, lane 0, with `res_last`.
- `start` re-asserted while `busy`=1 with different operands -> ignored; the output matches the first batch only.
